// File: rtl/mac_result_buf.sv
// Result buffer behind the pipelined MAC: a first-word-fall-through FIFO of {id, acc} entries.
// It raises accept_n early, leaving skid entries free for results still in flight.
// Optional `MAC_RESULT_BUF_ID_CHECK_EN adds a sticky id_err output.
// That output flags any arrive_id that breaks the +1 sequence.
module mac_result_buf #(
    parameter int acc_width = 16,
    parameter int id_width  = 1,
    parameter int depth     = 4,
    parameter int skid      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_out_n,
    input  logic [acc_width-1:0]         acc,
    input  logic [id_width-1:0]          arrive_id,
    output logic                         accept_n,
    input  logic                         pop,
    output logic                         valid_out,
    output logic [acc_width-1:0]         data_out,
    output logic [id_width-1:0]          id_out,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf
`ifdef MAC_RESULT_BUF_ID_CHECK_EN
    ,
    output logic                         id_err
`endif
);
    localparam int cnt_width = $clog2(depth + 1);
    localparam int ptr_width = $clog2(depth);
    localparam logic [ptr_width-1:0] LAST_PTR  = ptr_width'(depth - 1);
    localparam logic [cnt_width-1:0] DEPTH_CNT = cnt_width'(depth);
    localparam logic [cnt_width-1:0] THRESH    = cnt_width'(depth - skid);

    logic [id_width+acc_width-1:0] r_mem [depth];
    logic [ptr_width-1:0]          r_rd_ptr;
    logic [ptr_width-1:0]          r_wr_ptr;
    logic [cnt_width-1:0]          r_count;
    logic                          r_accept_n;
    logic                          r_ovf;

    logic                          w_push;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_pop_ok;
    logic                          w_push_ok;
    logic [cnt_width-1:0]          w_count_next;
    logic [id_width+acc_width-1:0] w_head;

    assign w_push    = ~push_out_n;
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = pop & ~w_empty;
    // A push into a full buffer still lands when the head leaves in the same cycle.
    assign w_push_ok = w_push & (~w_full | w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {arrive_id, acc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_accept_n <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_accept_n <= (w_count_next >= THRESH);
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef MAC_RESULT_BUF_ID_CHECK_EN
    logic [id_width-1:0] r_exp_id;
    logic                r_id_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_id <= '0;
            r_id_err <= 1'b0;
        end else if (w_push_ok) begin
            if (arrive_id != r_exp_id) begin
                r_id_err <= 1'b1;
            end
            r_exp_id <= arrive_id + 1'b1;
        end
    end

    assign id_err = r_id_err;
`endif

    assign w_head    = r_mem[r_rd_ptr];
    assign data_out  = w_empty ? '0 : w_head[acc_width-1:0];
    assign id_out    = w_empty ? '0 : w_head[id_width+acc_width-1:acc_width];
    assign valid_out = ~w_empty;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign accept_n  = r_accept_n;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_mac_result_buf.sv
// Self-checking bench for mac_result_buf (depth=4, skid=1, acc_width=16, id_width=2).
// Expected values come from a queue-based model of the buffer.
module tb_mac_result_buf;
    localparam int DEPTH = 4;
    localparam int SKID  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_out_n = 1'b1;
    logic [15:0] acc = '0;
    logic [1:0]  arrive_id = '0;
    logic        pop = 1'b0;
    logic        accept_n, valid_out, full, empty, ovf;
    logic [15:0] data_out;
    logic [1:0]  id_out;
    logic [2:0]  count;
`ifdef MAC_RESULT_BUF_ID_CHECK_EN
    logic        id_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [1:0]  d;
    } ent_t;

    ent_t     q[$];
    bit       m_ovf;
    bit       m_acc_n;
    bit       m_iderr;
    bit [1:0] m_exp;

    mac_result_buf #(
        .acc_width(16),
        .id_width (2),
        .depth    (DEPTH),
        .skid     (SKID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_out_n(push_out_n),
        .acc       (acc),
        .arrive_id (arrive_id),
        .accept_n  (accept_n),
        .pop       (pop),
        .valid_out (valid_out),
        .data_out  (data_out),
        .id_out    (id_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf)
`ifdef MAC_RESULT_BUF_ID_CHECK_EN
        ,
        .id_err    (id_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_update(input bit r, input bit p, input logic [15:0] a,
                                input logic [1:0] d, input bit pp);
        bit popok, pushok;
        ent_t e;
        if (r) begin
            q.delete();
            m_ovf = 0; m_acc_n = 0; m_exp = '0; m_iderr = 0;
        end else begin
            popok  = pp && (q.size() != 0);
            pushok = p && ((q.size() < DEPTH) || popok);
            if (p && !pushok) m_ovf = 1;
            if (pushok) begin
                if (d != m_exp) m_iderr = 1;
                m_exp = d + 2'd1;
            end
            if (popok) void'(q.pop_front());
            if (pushok) begin
                e.a = a; e.d = d;
                q.push_back(e);
            end
            m_acc_n = (q.size() >= DEPTH - SKID);
        end
    endtask

    // One clock: drive inputs, let the edge occur, update model, settle #1 past the edge.
    task automatic step(input bit r, input bit p, input logic [15:0] a,
                        input logic [1:0] d, input bit pp);
        rst = r; push_out_n = !p; acc = a; arrive_id = d; pop = pp;
        @(posedge clk);
        model_update(r, p, a, d, pp);
        #1;
        rst = 1'b0; push_out_n = 1'b1; pop = 1'b0;
    endtask

    function automatic logic [25:0] exp_vec();
        logic [15:0] ea;
        logic [1:0]  ed;
        int n;
        n  = q.size();
        ea = (n != 0) ? q[0].a : 16'h0;
        ed = (n != 0) ? q[0].d : 2'h0;
        return {3'(n), (n == DEPTH), (n == 0), (n != 0), ea, ed, m_acc_n, m_ovf};
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b1, 16'hDEAD, 2'd3, 1'b1);
        checks++;
        if ({count, empty, valid_out, data_out, accept_n, ovf, full} !==
            {3'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: cnt=%0d empty=%b vld=%b data=%h acc_n=%b ovf=%b full=%b, want 0 1 0 0000 0 0 0",
                     count, empty, valid_out, data_out, accept_n, ovf, full);
        end
    endtask

    task automatic test_fill_drain();
        logic [15:0] vals [3];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, vals[i], 2'(i), 1'b0);
            checks++;
            if ({count, accept_n, data_out} !== {3'(i + 1), (i == 2), 16'h0011}) begin
                errors++;
                $display("FAIL fill push%0d: cnt=%0d acc_n=%b head=%h, want %0d %b 0011",
                         i, count, accept_n, data_out, i + 1, (i == 2));
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid_out, data_out, id_out} !== {1'b1, vals[i], 2'(i)}) begin
                errors++;
                $display("FAIL drain head%0d: vld=%b data=%h id=%0d, want 1 %h %0d",
                         i, valid_out, data_out, id_out, vals[i], i);
            end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        checks++;
        if ({empty, accept_n, data_out} !== {1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL drain end: empty=%b acc_n=%b data=%h, want 1 0 0000",
                     empty, accept_n, data_out);
        end
        // pop while empty is ignored
        step(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if ({count, empty, ovf} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL empty pop: cnt=%0d empty=%b ovf=%b, want 0 1 0", count, empty, ovf);
        end
    endtask

    task automatic test_skid_ovf();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(16'h0101 * (i + 1)), 2'(i), 1'b0);
        checks++;
        if ({count, full, accept_n, ovf} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL skid accept: cnt=%0d full=%b acc_n=%b ovf=%b, want 4 1 1 0",
                     count, full, accept_n, ovf);
        end
        step(1'b0, 1'b1, 16'hBEEF, 2'd0, 1'b0);
        checks++;
        if ({count, ovf, data_out} !== {3'd4, 1'b1, 16'h0101}) begin
            errors++;
            $display("FAIL overflow drop: cnt=%0d ovf=%b head=%h, want 4 1 0101", count, ovf, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== 16'(16'h0101 * (i + 1))) begin
                errors++;
                $display("FAIL ovf drain%0d: data=%h, want %h", i, data_out, 16'(16'h0101 * (i + 1)));
            end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        checks++;
        if ({empty, ovf} !== {1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf sticky: empty=%b ovf=%b, want 1 1", empty, ovf);
        end
    endtask

    task automatic test_push_pop_full();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(16'h0041 + i), 2'(i), 1'b0);
        step(1'b0, 1'b1, 16'h0055, 2'd0, 1'b1);
        checks++;
        if ({count, ovf, full, data_out} !== {3'd4, 1'b0, 1'b1, 16'h0042}) begin
            errors++;
            $display("FAIL push+pop full: cnt=%0d ovf=%b full=%b head=%h, want 4 0 1 0042",
                     count, ovf, full, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== ((i == 3) ? 16'h0055 : 16'(16'h0042 + i))) begin
                errors++;
                $display("FAIL push+pop drain%0d: data=%h, want %h", i, data_out,
                         (i == 3) ? 16'h0055 : 16'(16'h0042 + i));
            end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 16'd0, 2'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if ({data_out, count} !== {16'(i - 1), 3'd1}) begin
                errors++;
                $display("FAIL wrap%0d: data=%0d cnt=%0d, want %0d 1", i, data_out, count, i - 1);
            end
            step(1'b0, (i < 10), 16'(i), 2'(i), 1'b1);
        end
        checks++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL wrap end: empty=%b cnt=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_random();
        logic [25:0] obs;
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            step((c == 200), ($urandom_range(99) < 60), 16'($urandom), 2'($urandom), ($urandom_range(99) < 45));
            obs = {count, full, empty, valid_out, data_out, id_out, accept_n, ovf};
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", c, obs, exp_vec());
            end
`ifdef MAC_RESULT_BUF_ID_CHECK_EN
            checks++;
            if (id_err !== m_iderr) begin
                errors++;
                $display("FAIL random id_err cycle %0d: got %b want %b", c, id_err, m_iderr);
            end
`endif
        end
    endtask

`ifdef MAC_RESULT_BUF_ID_CHECK_EN
    task automatic test_id_check();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 16'h1, 2'd0, 1'b0);
        step(1'b0, 1'b1, 16'h2, 2'd1, 1'b0);
        checks++;
        if (id_err !== 1'b0) begin
            errors++;
            $display("FAIL id in-order: id_err=%b, want 0", id_err);
        end
        step(1'b0, 1'b1, 16'h3, 2'd3, 1'b0);
        checks++;
        if (id_err !== 1'b1) begin
            errors++;
            $display("FAIL id skip: id_err=%b, want 1", id_err);
        end
        step(1'b1, 1'b0, '0, '0, 1'b0);
        checks++;
        if (id_err !== 1'b0) begin
            errors++;
            $display("FAIL id reset: id_err=%b, want 0", id_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_skid_ovf();
        test_push_pop_full();
        test_wrap();
`ifdef MAC_RESULT_BUF_ID_CHECK_EN
        test_id_check();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_result_buf.md
Name: mac_result_buf

Overview:
- Downstream result buffer for the pipelined MAC. Captures each accumulated result the MAC pushes out, together with its launch ID, into a small first-word-fall-through FIFO.
- Drives the MAC's accept_n back-pressure input so that results still in flight never overflow the buffer.
- Presents results to a consumer through a valid/pop handshake.

Parameters:
- acc_width, 16, width of the MAC accumulator result (2..256)
- id_width, 1, width of the launch/arrive ID (1..24)
- depth, 4, FIFO entries (2..16)
- skid, 1, entries held in reserve for results already in the MAC pipeline when accept_n rises (0..depth-1)
- cnt_width = ceil(log2(depth+1)), derived locally, not overridable

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- push_out_n  input  1  from MAC; low = result valid this cycle
- acc  input  acc_width  MAC result, sampled when push_out_n=0
- arrive_id  input  id_width  ID of that result
- accept_n  output  1  to MAC; high = stop presenting new results
- pop  input  1  consumer takes the head entry
- valid_out  output  1  head entry available (not empty)
- data_out  output  acc_width  head result; 0 when empty
- id_out  output  id_width  head ID; 0 when empty
- count  output  cnt_width  current occupancy
- full  output  1  count == depth
- empty  output  1  count == 0
- ovf  output  1  sticky: a push was dropped

Behaviour:
- Reset (rst=1 at a clock edge): rd_ptr=0, wr_ptr=0, count=0, accept_n=0, ovf=0, full=0, empty=1, valid_out=0, data_out=0, id_out=0. Memory contents are not reset. A reset mid-operation discards all entries.
- push = (push_out_n==0). pop_ok = pop & !empty.
- push_ok = push & (!full | pop_ok). A push while full with a same-cycle pop is accepted.
- Write: on push_ok, mem[wr_ptr] <= {arrive_id, acc}; wr_ptr advances, wrapping depth-1 -> 0.
- Read: on pop_ok, rd_ptr advances with the same wrap. A pop while empty is ignored and causes no error.
- Count: count_next = count + push_ok - pop_ok. Simultaneous push and pop leaves count unchanged.
- FWFT output: data_out/id_out are combinational from mem[rd_ptr] when !empty, else 0. An entry written at edge N is visible at data_out after edge N, so latency push -> valid_out is 1 cycle.
- full/empty/valid_out are decoded from the registered count.
- accept_n is a register: accept_n <= (count_next >= depth - skid).
  - Updates one cycle after the occupancy change.
  - skid covers results that arrive in that window.
  - With skid=0, accept_n rises only at full.
- Overflow: push & full & !pop_ok drops the result; ovf <= 1 and stays 1 until rst. Pointers and count are unchanged on a dropped push.
- Arithmetic: unsigned pointer and count math, modulo depth for the pointers. depth need not be a power of two; pointers compare against depth-1 explicitly.

Optional Feature:
- Macro: MAC_RESULT_BUF_ID_CHECK_EN
- Defined:
  - Adds output id_err (1 bit) and an internal expected-ID counter (id_width bits, reset 0).
  - On each push_ok: if arrive_id != expected, id_err <= 1 (sticky until rst). expected <= arrive_id + 1, modulo 2^id_width.
  - Dropped pushes do not update expected.
- Not defined: no id_err port and no checker logic; behaviour is otherwise identical.

Test Plan (depth=4, skid=1, acc_width=16, id_width=2 unless noted):
- Reset: after rst=1 for 1 cycle -> count=0, empty=1, valid_out=0, data_out=0, accept_n=0, ovf=0.
- Fill and drain:
  - Push 0x0011/id0, 0x0022/id1, 0x0033/id2 on consecutive cycles, no pop.
  - After the 3rd push, count=3 and accept_n=1 on the following edge.
  - Pop 3 times -> data_out 0x0011, 0x0022, 0x0033 in order. Then empty=1 and accept_n=0.
- Skid and overflow:
  - Continue pushing while accept_n=1: the 4th push is accepted (full=1).
  - 5th push 0xBEEF with no pop -> dropped, ovf=1, count=4; ovf stays 1 after draining.
- Simultaneous push and pop at full: count=4, push 0x0055 with pop=1 -> head advances, count stays 4, ovf stays 0. 0x0055 emerges last.
- Wrap-around: 10 push/pop pairs with acc=i, i=0..9, one cycle apart -> data_out sequence 0..9, pointers wrap twice, count never exceeds 1.
- With MAC_RESULT_BUF_ID_CHECK_EN defined: push IDs 0, 1, 3 -> id_err=0 after the second push, 1 after the third; rst clears it.
